// File: rtl/spi_reg_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for spi_reg_file.
package spi_reg_pkg;

  localparam logic [6:0] ADR_ID        = 7'h00;
  localparam logic [6:0] ADR_CTRL      = 7'h01;
  localparam logic [6:0] ADR_STATUS    = 7'h02;
  localparam logic [6:0] ADR_LEVEL     = 7'h03;
  localparam logic [6:0] ADR_FIFO_DATA = 7'h04;
  localparam logic [6:0] ADR_SCRATCH   = 7'h05;
  localparam logic [6:0] ADR_DROP_CNT  = 7'h06;
  localparam logic [6:0] ADR_THRESH    = 7'h07;

  localparam int CTRL_CAPTURE_EN = 0;
  localparam int CTRL_FIFO_CLEAR = 1;

  localparam int STATUS_EMPTY    = 0;
  localparam int STATUS_FULL     = 1;
  localparam int STATUS_OVERFLOW = 2;

  localparam logic [7:0] THRESH_RESET = 8'h08;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACKED = 1'b1
  } state_e;

  // A 256-deep FIFO reports 256 in 9 bits; clamp it into the 8-bit register.
  function automatic logic [7:0] sat_level(input logic [8:0] lvl);
    return lvl[8] ? 8'hFF : lvl[7:0];
  endfunction

endpackage

// File: rtl/spi_reg_fifo.sv
// Capture FIFO: single-clock, power-of-two depth, combinational head, synchronous clear.
module spi_reg_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CNT_MAX);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
      else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_reg_file.sv
// SPI-bridge register file for a USB sniffer: req/ack handshake, control/status and capture FIFO.
// Optional SPI_REG_FILE_IRQ_EN adds the THRESH register (0x07) and the irq output.
module spi_reg_file
  import spi_reg_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic       reg_clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] adr,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic [7:0] rdata,
  input  logic       cap_valid,
  input  logic [7:0] cap_data,
  output logic       capture_en
`ifdef SPI_REG_FILE_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_e     state_q;
  logic       ack_q;
  logic [7:0] rdata_q;

  logic       capture_en_q, capture_en_d;
  logic       clr_q, clr_d;
  logic       ovf_q, ovf_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
`ifdef SPI_REG_FILE_IRQ_EN
  logic [7:0] thresh_q, thresh_d;
  logic       irq_q;
`endif

  logic        access, wr, rd;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [7:0]  fifo_head, rd_val;
  logic [AW:0] fifo_level;
  logic [8:0]  level9;

  // Exactly one access per request: only the IDLE->ACKED edge has side effects.
  assign access = (state_q == ST_IDLE) && req;
  assign wr     = access && rw;
  assign rd     = access && !rw;
  assign level9 = 9'(fifo_level);

  assign fifo_pop  = rd && (adr == ADR_FIFO_DATA) && !fifo_empty;
  assign fifo_push = cap_valid && capture_en_q && (!fifo_full || fifo_pop);
  assign drop      = cap_valid && capture_en_q && fifo_full && !fifo_pop;

  spi_reg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (reg_clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (clr_q),
    .wdata (cap_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    rd_val = '0;
    case (adr)
      ADR_ID:       rd_val = ID_VALUE;
      ADR_CTRL:     rd_val[CTRL_CAPTURE_EN] = capture_en_q;
      ADR_STATUS: begin
        rd_val[STATUS_EMPTY]    = fifo_empty;
        rd_val[STATUS_FULL]     = fifo_full;
        rd_val[STATUS_OVERFLOW] = ovf_q;
      end
      ADR_LEVEL:     rd_val = sat_level(level9);
      ADR_FIFO_DATA: rd_val = fifo_empty ? 8'h00 : fifo_head;
      ADR_SCRATCH:   rd_val = scratch_q;
      ADR_DROP_CNT:  rd_val = drop_cnt_q;
`ifdef SPI_REG_FILE_IRQ_EN
      ADR_THRESH:    rd_val = thresh_q;
`endif
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    capture_en_d = capture_en_q;
    clr_d        = 1'b0;
    scratch_d    = scratch_q;
    ovf_d        = ovf_q;
    drop_cnt_d   = drop_cnt_q;
`ifdef SPI_REG_FILE_IRQ_EN
    thresh_d     = thresh_q;
`endif
    if (wr) begin
      case (adr)
        ADR_CTRL: begin
          capture_en_d = wdata[CTRL_CAPTURE_EN];
          clr_d        = wdata[CTRL_FIFO_CLEAR];
        end
        ADR_STATUS:   if (wdata[STATUS_OVERFLOW]) ovf_d = 1'b0;
        ADR_SCRATCH:  scratch_d  = wdata;
        ADR_DROP_CNT: drop_cnt_d = 8'h00;
`ifdef SPI_REG_FILE_IRQ_EN
        ADR_THRESH:   thresh_d   = wdata;
`endif
        default: ;
      endcase
    end
    // A drop in the same cycle as a clear still counts, so no event is lost.
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'h01;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (rst) begin
      capture_en_q <= 1'b0;
      clr_q        <= 1'b0;
      scratch_q    <= 8'h00;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= 8'h00;
`ifdef SPI_REG_FILE_IRQ_EN
      thresh_q     <= THRESH_RESET;
      irq_q        <= 1'b0;
`endif
    end else begin
      capture_en_q <= capture_en_d;
      clr_q        <= clr_d;
      scratch_q    <= scratch_d;
      ovf_q        <= ovf_d;
      drop_cnt_q   <= drop_cnt_d;
`ifdef SPI_REG_FILE_IRQ_EN
      thresh_q     <= thresh_d;
      irq_q        <= capture_en_q && (level9 >= {1'b0, thresh_q});
`endif
    end
  end

  always_ff @(posedge reg_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            ack_q   <= 1'b1;
            rdata_q <= rw ? 8'h00 : rd_val;
            state_q <= ST_ACKED;
          end
        end
        ST_ACKED: begin
          if (!req) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign capture_en = capture_en_q;
`ifdef SPI_REG_FILE_IRQ_EN
  assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_spi_reg_file.sv
// Directed bench for spi_reg_file: handshake, register map, capture FIFO, overflow and reset.
module tb_spi_reg_file;

  logic       reg_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] adr = '0;
  logic [7:0] wdata = '0;
  logic       ack;
  logic [7:0] rdata;
  logic       cap_valid = 1'b0;
  logic [7:0] cap_data = '0;
  logic       capture_en;
`ifdef SPI_REG_FILE_IRQ_EN
  logic       irq;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 reg_clk = ~reg_clk;

  spi_reg_file #(.FIFO_DEPTH(16), .ID_VALUE(8'hA5)) dut (
    .reg_clk    (reg_clk),
    .rst        (rst),
    .req        (req),
    .rw         (rw),
    .adr        (adr),
    .wdata      (wdata),
    .ack        (ack),
    .rdata      (rdata),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .capture_en (capture_en)
`ifdef SPI_REG_FILE_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // One full handshake; lat counts edges from req to ack (capped at 8).
  task automatic bus(input logic w, input logic [6:0] a, input logic [7:0] d,
                     output logic [7:0] rd0, output int lat,
                     output logic [7:0] rd_hold, output logic ack_off);
    @(negedge reg_clk);
    req = 1'b1; rw = w; adr = a; wdata = d;
    lat = 0;
    do begin
      @(posedge reg_clk); #1;
      lat++;
    end while (!ack && lat < 8);
    rd0 = rdata;
    @(posedge reg_clk); #1;
    rd_hold = rdata;
    @(negedge reg_clk);
    req = 1'b0;
    @(posedge reg_clk); #1;
    ack_off = ack;
  endtask

  task automatic rd_reg(input logic [6:0] a, output logic [7:0] d);
    logic [7:0] h; int l; logic o;
    bus(1'b0, a, 8'h00, d, l, h, o);
  endtask

  task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] r, h; int l; logic o;
    bus(1'b1, a, d, r, l, h, o);
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    @(negedge reg_clk);
    cap_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      cap_data = base + 8'(i);
      @(negedge reg_clk);
    end
    cap_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(posedge reg_clk);
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", rdata); end
    n_cmp++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL reset_capen got %b want 0", capture_en); end
    @(negedge reg_clk); rst = 1'b0;
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL reset_status got %h want 01", v); end
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_level got %h want 00", v); end
    rd_reg(7'h05, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_scratch got %h want 00", v); end
  endtask

  task automatic test_scratch;
    logic [7:0] r, h; int l; logic o;
    wr_reg(7'h05, 8'h3C);
    bus(1'b0, 7'h05, 8'h00, r, l, h, o);
    n_cmp++; if (l !== 1) begin n_fail++; $display("FAIL scratch_latency got %0d want 1", l); end
    n_cmp++; if (r !== 8'h3C) begin n_fail++; $display("FAIL scratch_data got %h want 3c", r); end
    n_cmp++; if (h !== 8'h3C) begin n_fail++; $display("FAIL scratch_hold got %h want 3c", h); end
    n_cmp++; if (o !== 1'b0) begin n_fail++; $display("FAIL scratch_ack_drop got %b want 0", o); end
  endtask

  task automatic test_id_unmapped;
    logic [7:0] r, h, v; int l; logic o;
    rd_reg(7'h00, v);
    n_cmp++; if (v !== 8'hA5) begin n_fail++; $display("FAIL id got %h want a5", v); end
    bus(1'b0, 7'h7F, 8'h00, r, l, h, o);
    n_cmp++; if (l !== 1) begin n_fail++; $display("FAIL unmapped_latency got %0d want 1", l); end
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL unmapped_data got %h want 00", r); end
    wr_reg(7'h7F, 8'hFF);
    rd_reg(7'h05, v);
    n_cmp++; if (v !== 8'h3C) begin n_fail++; $display("FAIL unmapped_write got %h want 3c", v); end
    rd_reg(7'h07, v);
`ifdef SPI_REG_FILE_IRQ_EN
    n_cmp++; if (v !== 8'h08) begin n_fail++; $display("FAIL thresh_reset got %h want 08", v); end
`else
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL addr7_unmapped got %h want 00", v); end
`endif
  endtask

  task automatic test_fifo_basic;
    logic [7:0] v;
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h00;
    wr_reg(7'h01, 8'h01);
    n_cmp++; if (capture_en !== 1'b1) begin n_fail++; $display("FAIL capen_on got %b want 1", capture_en); end
    push_bytes(8'h11, 1); push_bytes(8'h22, 1); push_bytes(8'h33, 1);
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h03) begin n_fail++; $display("FAIL basic_level got %h want 03", v); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(7'h04, v);
      n_cmp++; if (v !== exp_q[i]) begin n_fail++; $display("FAIL basic_pop%0d got %h want %h", i, v, exp_q[i]); end
    end
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL basic_status got %h want 01", v); end
  endtask

  task automatic test_capture_disabled;
    logic [7:0] v;
    wr_reg(7'h01, 8'h00);
    push_bytes(8'hAA, 2);
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL disabled_level got %h want 00", v); end
    wr_reg(7'h01, 8'h01);
  endtask

  task automatic test_overflow_clear;
    logic [7:0] v;
    push_bytes(8'h40, 20);
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h06) begin n_fail++; $display("FAIL ovf_status got %h want 06", v); end
    rd_reg(7'h06, v);
    n_cmp++; if (v !== 8'h04) begin n_fail++; $display("FAIL ovf_dropcnt got %h want 04", v); end
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h10) begin n_fail++; $display("FAIL ovf_level got %h want 10", v); end
    wr_reg(7'h01, 8'h03);
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL clear_level got %h want 00", v); end
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h05) begin n_fail++; $display("FAIL clear_status got %h want 05", v); end
    rd_reg(7'h01, v);
    n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL clear_ctrl got %h want 01", v); end
    rd_reg(7'h06, v);
    n_cmp++; if (v !== 8'h04) begin n_fail++; $display("FAIL clear_dropcnt got %h want 04", v); end
    wr_reg(7'h02, 8'h04);
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL w1c_status got %h want 01", v); end
  endtask

  task automatic test_push_pop_full;
    logic [7:0] v;
    int cyc;
    push_bytes(8'h50, 16);
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h02) begin n_fail++; $display("FAIL full_status got %h want 02", v); end
    @(negedge reg_clk);
    req = 1'b1; rw = 1'b0; adr = 7'h04;
    cap_valid = 1'b1; cap_data = 8'h77;
    @(posedge reg_clk); #1;
    cap_valid = 1'b0;
    cyc = 1;
    while (!ack && cyc < 8) begin @(posedge reg_clk); #1; cyc++; end
    n_cmp++; if (rdata !== 8'h50) begin n_fail++; $display("FAIL pushpop_data got %h want 50", rdata); end
    @(negedge reg_clk); req = 1'b0;
    @(posedge reg_clk); #1;
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h10) begin n_fail++; $display("FAIL pushpop_level got %h want 10", v); end
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h02) begin n_fail++; $display("FAIL pushpop_status got %h want 02", v); end
    rd_reg(7'h04, v);
    n_cmp++; if (v !== 8'h51) begin n_fail++; $display("FAIL pushpop_next got %h want 51", v); end
  endtask

  task automatic test_drop_saturate;
    logic [7:0] v;
    push_bytes(8'h00, 261);
    rd_reg(7'h06, v);
    n_cmp++; if (v !== 8'hFF) begin n_fail++; $display("FAIL drop_sat got %h want ff", v); end
    wr_reg(7'h06, 8'h5A);
    rd_reg(7'h06, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL drop_wclr got %h want 00", v); end
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h06) begin n_fail++; $display("FAIL drop_status got %h want 06", v); end
  endtask

  task automatic test_reset_inflight;
    logic [7:0] v;
    int cyc;
    @(negedge reg_clk);
    req = 1'b1; rw = 1'b0; adr = 7'h05;
    cyc = 0;
    do begin @(posedge reg_clk); #1; cyc++; end while (!ack && cyc < 8);
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL inflight_ack got %b want 1", ack); end
    @(negedge reg_clk); rst = 1'b1;
    @(posedge reg_clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", ack); end
    n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h want 00", rdata); end
    n_cmp++; if (capture_en !== 1'b0) begin n_fail++; $display("FAIL rst_capen got %b want 0", capture_en); end
    @(negedge reg_clk); rst = 1'b0; req = 1'b0;
    rd_reg(7'h03, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_level got %h want 00", v); end
    rd_reg(7'h05, v);
    n_cmp++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_scratch got %h want 00", v); end
    rd_reg(7'h02, v);
    n_cmp++; if (v !== 8'h01) begin n_fail++; $display("FAIL rst_status got %h want 01", v); end
  endtask

  initial begin
    test_reset;
    test_scratch;
    test_id_unmapped;
    test_fifo_basic;
    test_capture_disabled;
    test_overflow_clear;
    test_push_pop_full;
    test_drop_saturate;
    test_reset_inflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_file.md
SPI_REG_FILE -- requirements
Module: spi_reg_file

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, capture FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, value returned by the ID register.
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 SHALL have port reg_clk, input, 1, single clock for all logic (the SPI register-bus clock).
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, 1, register-bus request level from the SPI bridge.
REQ-007 SHALL have port rw, input, 1, 0 = read, 1 = write; valid while req=1.
REQ-008 SHALL have port adr, input, 7, register address; valid while req=1.
REQ-009 SHALL have port wdata, input, 8, write data; valid while req=1.
REQ-010 SHALL have port ack, output, 1, access-complete indication.
REQ-011 SHALL have port rdata, output, 8, read data; valid while ack=1.
REQ-012 SHALL have port cap_valid, input, 1, captured USB byte strobe.
REQ-013 SHALL have port cap_data, input, 8, captured USB byte.
REQ-014 SHALL have port capture_en, output, 1, CTRL[0], enables the sniffer front end.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and ACKED.
REQ-016 In IDLE with req=1, SHALL perform exactly one access, register rdata, and set ack=1 on the next edge, then enter ACKED.
REQ-017 In ACKED, SHALL hold ack=1 and rdata stable while req=1; when req=0, SHALL clear ack on the next edge and return to IDLE.
REQ-018 SHALL implement the register map: 0x00 ID (RO) = ID_VALUE; 0x01 CTRL (RW) with bit0 capture_en and bit1 fifo_clear (self-clearing, reads 0); 0x02 STATUS (RO) with bit0 empty, bit1 full, and bit2 overflow (W1C); 0x03 LEVEL (RO); 0x04 FIFO_DATA (RO, read pops); 0x05 SCRATCH (RW); 0x06 DROP_CNT (RO, write clears).
REQ-019 Unmapped addresses SHALL read 0x00, ignore writes, and still ack.
REQ-020 cap_valid=1 with capture_en=1 and FIFO not full SHALL push cap_data; cap_valid is ignored while capture_en=0.
REQ-021 A push to a full FIFO SHALL drop the byte, set overflow sticky, and increment DROP_CNT, saturating at 0xFF.
REQ-022 A FIFO_DATA read SHALL return the head byte and pop it; a read while empty SHALL return 0x00 with no state change.
REQ-023 A simultaneous push and pop SHALL leave LEVEL unchanged; a push to a full FIFO with a simultaneous pop SHALL be accepted.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; LEVEL SHALL be log2(FIFO_DEPTH)+1 bits, zero-extended or saturated to 8 bits on read.
REQ-025 Writing 1 to fifo_clear SHALL empty the FIFO on the following edge; overflow and DROP_CNT are unaffected.

Reset
REQ-026 rst=1 SHALL force ack=0, rdata=0x00, capture_en=0, SCRATCH=0, overflow=0, DROP_CNT=0, FIFO empty, and state IDLE, including during an in-flight access (no ack issued).

Configuration
REQ-027 With SPI_REG_FILE_IRQ_EN defined, SHALL add output irq (1 bit) and register 0x07 THRESH (RW, reset 0x08), with irq=1 when capture_en=1 and LEVEL >= THRESH, registered, reset 0.
REQ-028 Without SPI_REG_FILE_IRQ_EN, no irq port SHALL exist and 0x07 SHALL behave as unmapped.

Structure
REQ-029 Register addresses, CTRL/STATUS bit indices, and FSM state encodings SHALL live in shared package spi_reg_pkg.
REQ-030 The capture FIFO SHALL be sub-module spi_reg_fifo (push, pop, clear, full, empty, level).

Verification
REQ-031 Write 0x3C to 0x05, then read 0x05 -> ack one cycle after req, rdata=0x3C held until req drops.
REQ-032 Read 0x00 -> rdata=0xA5; read 0x7F -> rdata=0x00, ack asserted.
REQ-033 capture_en=1, push 0x11,0x22,0x33 -> LEVEL=3; three FIFO_DATA reads return 0x11,0x22,0x33; fourth read returns 0x00.
REQ-034 Push 20 bytes into a 16-deep FIFO -> STATUS=0x06, DROP_CNT=4; write 0x04 to 0x02 -> overflow cleared.
REQ-035 Push while popping on a full FIFO -> LEVEL stays 16, no overflow.
REQ-036 Assert rst while ack=1 -> ack=0 next edge, LEVEL=0, capture_en=0.
